pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the NN CPU pipeline. It drives the stall, flush and hold controls around the decode/execute pipeline register, and selects forwarding sources for the three execute-stage operands. It inserts load-use bubbles and freezes the front end while a multi-cycle ALU2 MAC operation occupies execute. Sits beside the IF/ID, ID/EX and EX/MEM registers; purely a control block, no datapath.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared CPU package for the hazard controller.
// Holds the hazard FSM state encoding, the forwarding select codes and
// the ALU2 MAC function code that the control unit also uses.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [2:0] MAC_FUNCT_CODE = 3'b110;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// fwd_sel: forwarding source selector for one execute-stage operand.
// Ports:
//   i_src        operand source register specifier
//   i_wreg_m     MEM-stage destination, i_regwrite_m its write enable
//   i_wreg_w     WB-stage destination,  i_regwrite_w its write enable
//   o_fwd        FWD_MEM / FWD_WB / FWD_RF; MEM wins, r0 never forwarded
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REGISTER_SIZE = 6
) (
    input  logic [REGISTER_SIZE-1:0] i_src,
    input  logic [REGISTER_SIZE-1:0] i_wreg_m,
    input  logic                     i_regwrite_m,
    input  logic [REGISTER_SIZE-1:0] i_wreg_w,
    input  logic                     i_regwrite_w,
    output logic [1:0]               o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_regwrite_m && (i_wreg_m != '0) && (i_wreg_m == i_src);
    assign w_hit_w = i_regwrite_w && (i_wreg_w != '0) && (i_wreg_w == i_src);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m)
            o_fwd = FWD_MEM;
        else if (w_hit_w)
            o_fwd = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the NN CPU pipeline.
// Generates stall/flush controls around ID/EX and EX/MEM, load-use bubbles,
// multi-cycle ALU2 MAC front-end freeze, and per-operand forwarding selects.
// Ports:
//   CLK, RST_N                       clock, async active-low reset
//   RsD, RtD                         decode source specifiers
//   RsE, RtE, RcE                    execute source specifiers (A/B/C)
//   WriteRegE/M/W, RegWriteE/M/W     destination and write enable per stage
//   MemtoRegE                        execute instruction is a load
//   ALU2CntrlE                       execute ALU2 control
//   StallF, StallD, StallE           hold PC, IF/ID, ID/EX
//   FlushE, FlushM                   bubble into ID/EX, EX/MEM
//   ForwardAE/BE/CE                  operand source selects
//   MacDone                          MAC result leaves EX this cycle
//   StallCount                       saturating count of StallD cycles
//                                    (only with HAZARD_PERF_CNT_EN defined)
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int                        REGISTER_SIZE  = 6,
    parameter int                        ALU_FUNCT_BITS = 3,
    parameter logic [ALU_FUNCT_BITS-1:0] MAC_FUNCT      = ALU_FUNCT_BITS'(MAC_FUNCT_CODE),
    parameter int                        MAC_LATENCY    = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [REGISTER_SIZE-1:0]  RsD,
    input  logic [REGISTER_SIZE-1:0]  RtD,
    input  logic [REGISTER_SIZE-1:0]  RsE,
    input  logic [REGISTER_SIZE-1:0]  RtE,
    input  logic [REGISTER_SIZE-1:0]  RcE,
    input  logic [REGISTER_SIZE-1:0]  WriteRegE,
    input  logic [REGISTER_SIZE-1:0]  WriteRegM,
    input  logic [REGISTER_SIZE-1:0]  WriteRegW,
    input  logic                      RegWriteE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      MemtoRegE,
    input  logic [ALU_FUNCT_BITS-1:0] ALU2CntrlE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic [1:0]                ForwardCE,
    output logic                      MacDone
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               StallCount
`endif
);

    hz_state_t  r_state;
    logic [3:0] r_cnt;

    logic w_mac;
    logic w_load_use;
    logic w_mac_stall;
    logic w_lu_bubble;

    assign w_mac      = (ALU2CntrlE == MAC_FUNCT);
    assign w_load_use = MemtoRegE && RegWriteE && (WriteRegE != '0) &&
                        ((WriteRegE == RsD) || (WriteRegE == RtD));

    // BUSY holds cnt+1 more cycles after the RUN trigger cycle, giving
    // MAC_LATENCY stall cycles in total before DRAIN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mac) begin
                        r_cnt   <= 4'(MAC_LATENCY - 2);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0)
                        r_state <= DRAIN;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                DRAIN:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // MAC stall covers the RUN trigger cycle and all of BUSY. A load-use
    // during a MAC stall is moot (front end already frozen), so it only
    // bubbles when no MAC stall is active, which also covers DRAIN.
    always_comb begin
        w_mac_stall = RST_N && ((r_state == BUSY) || ((r_state == RUN) && w_mac));
        w_lu_bubble = RST_N && w_load_use && !w_mac_stall;
        StallF      = w_mac_stall || w_lu_bubble;
        StallD      = w_mac_stall || w_lu_bubble;
        StallE      = w_mac_stall;
        FlushM      = w_mac_stall;
        FlushE      = w_lu_bubble;
        MacDone     = RST_N && (r_state == DRAIN);
    end

    fwd_sel #(.REGISTER_SIZE(REGISTER_SIZE)) u_fwd_a (
        .i_src        (RsE),
        .i_wreg_m     (WriteRegM),
        .i_regwrite_m (RegWriteM),
        .i_wreg_w     (WriteRegW),
        .i_regwrite_w (RegWriteW),
        .o_fwd        (ForwardAE)
    );

    fwd_sel #(.REGISTER_SIZE(REGISTER_SIZE)) u_fwd_b (
        .i_src        (RtE),
        .i_wreg_m     (WriteRegM),
        .i_regwrite_m (RegWriteM),
        .i_wreg_w     (WriteRegW),
        .i_regwrite_w (RegWriteW),
        .o_fwd        (ForwardBE)
    );

    fwd_sel #(.REGISTER_SIZE(REGISTER_SIZE)) u_fwd_c (
        .i_src        (RcE),
        .i_wreg_m     (WriteRegM),
        .i_regwrite_m (RegWriteM),
        .i_wreg_w     (WriteRegW),
        .i_regwrite_w (RegWriteW),
        .o_fwd        (ForwardCE)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_stall_count <= '0;
        else if (StallD && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign StallCount = r_stall_count;
`endif

endmodule
